// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

    // Stall sequencer states; encoding is fixed so waveforms decode consistently.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO            = 5'd0;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX writes a register the instruction in ID reads.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hit
);

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        hit = ex_mem_read && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS datapath.
// Handles load-use stalls, taken-branch flushes and data-memory wait states,
// with a watchdog that raises a sticky mem_err when memory stays busy too long.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int unsigned      WaitW    = $clog2(MEM_TIMEOUT + 1);
    // Counter value on the busy cycle that completes the timeout window.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    hz_state_t        state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             mem_err_q, mem_err_d;
    logic             lu_hit;

    load_use_detect u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hit         (lu_hit)
    );

    // Next-state and zero-latency pipeline controls from current state and inputs.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        state_d      = StRun;
        wait_d       = '0;
        mem_err_d    = mem_err_q;

        case (state_q)
            StRun, StLuStall: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                    if (MEM_TIMEOUT <= 1) begin
                        // A one-cycle window expires on its first busy cycle.
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d  = WaitW'(1);
                        state_d = StMemWait;
                    end
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if ((state_q == StRun) && lu_hit) begin
                    // The bubble cycle resolves the hazard, so LU_STALL skips detection.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = StLuStall;
                end
            end
            StMemWait: begin
                // EX is frozen here, so a branch indication is stale and ignored.
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                    if (wait_q == WaitLast) begin
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d  = wait_q + WaitW'(1);
                        state_d = StMemWait;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Reset drives the pipe into a flushed, bubbled, non-advancing state.
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_hold  = 1'b0;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    // The flag reads clear for the whole reset cycle, not only after it.
    always_comb begin
        mem_err = mem_err_q & ~rst;
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating counts of stalled-PC cycles and IF/ID flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (if_id_flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // Counters read zero while reset is held.
    always_comb begin
        stall_count = rst ? '0 : stall_q;
        flush_count = rst ? '0 : flush_q;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (built with MEM_TIMEOUT=4).
module tb_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
    logic       ex_mem_hold, mem_err;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    hazard_ctrl #(
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_hold     (ex_mem_hold),
        .mem_err         (mem_err)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Output bundle {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
    //                ex_mem_hold, mem_err}
    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0010000;
    localparam logic [6:0] O_FLUSH = 7'b1101100;
    localparam logic [6:0] O_HOLD  = 7'b0000010;
    localparam logic [6:0] O_RST   = 7'b0011100;

    logic [6:0] obs;
    always_comb obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
                       ex_mem_hold, mem_err};

    // Reference model: described by busy run length and "just bubbled" history.
    bit         m_err, m_in_wait, m_after_bubble;
    int         m_busy_run, m_stalls, m_flushes;
    logic [6:0] m_exp;

    function automatic void model_eval();
        bit hit;
        bit quiet;
        hit = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        quiet = !mem_busy && !m_in_wait;
        if (rst) begin
            m_exp = O_RST;
        end else if (mem_busy) begin
            m_exp = O_HOLD;
        end else if (quiet && ex_branch_taken) begin
            m_exp = O_FLUSH;
        end else if (quiet && !m_after_bubble && hit) begin
            m_exp = O_STALL;
        end else begin
            m_exp = O_DEF;
        end
        if (!rst) m_exp[0] = m_err;
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_err = 0; m_in_wait = 0; m_after_bubble = 0;
            m_busy_run = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (!m_exp[6] && m_stalls < 65535) m_stalls++;
            if (m_exp[3] && m_flushes < 65535) m_flushes++;
            m_after_bubble = m_exp[4];
            if (mem_busy) begin
                m_busy_run++;
                if (m_busy_run == TO) begin
                    m_err = 1; m_busy_run = 0; m_in_wait = 0;
                end else begin
                    m_in_wait = 1;
                end
            end else begin
                m_busy_run = 0;
                m_in_wait  = 0;
            end
        end
    endfunction

    task automatic quiet_inputs();
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
        id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        quiet_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; mem_busy = 1; ex_branch_taken = 1;
        ex_mem_read = 1; ex_rt = 5'd7; id_rs = 5'd7;
        @(negedge clk);
        vectors++;
        if (obs !== O_RST) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, O_RST);
        end
        next_cycle();
        rst = 0; quiet_inputs();
        @(negedge clk);
        vectors++;
        if (obs !== O_DEF) begin
            errors++;
            $display("FAIL post_reset_defaults: got %b want %b", obs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        vectors++;
        if (obs !== O_STALL) begin
            errors++;
            $display("FAIL lu_stall: got %b want %b", obs, O_STALL);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (obs !== O_DEF) begin
            errors++;
            $display("FAIL lu_single_bubble: got %b want %b", obs, O_DEF);
        end
        next_cycle();
        // rt only counts as a source when the instruction reads it.
        id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 0;
        @(negedge clk);
        vectors++;
        if (obs !== O_DEF) begin
            errors++;
            $display("FAIL lu_rt_unused: got %b want %b", obs, O_DEF);
        end
        next_cycle();
        id_uses_rt = 1;
        @(negedge clk);
        vectors++;
        if (obs !== O_STALL) begin
            errors++;
            $display("FAIL lu_rt_used: got %b want %b", obs, O_STALL);
        end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
        @(negedge clk);
        vectors++;
        if (obs !== O_DEF) begin
            errors++;
            $display("FAIL zero_reg_no_stall: got %b want %b", obs, O_DEF);
        end
        next_cycle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1;
        @(negedge clk);
        vectors++;
        if (obs !== O_FLUSH) begin
            errors++;
            $display("FAIL branch_over_lu: got %b want %b", obs, O_FLUSH);
        end
        next_cycle();
        // Still in RUN, so the same hazard now stalls.
        ex_branch_taken = 0;
        @(negedge clk);
        vectors++;
        if (obs !== O_STALL) begin
            errors++;
            $display("FAIL branch_stays_run: got %b want %b", obs, O_STALL);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if (flush_count !== 16'd1) begin
            errors++;
            $display("FAIL flush_count: got %0d want 1", flush_count);
        end
`endif
        next_cycle();
        mem_busy = 1; ex_branch_taken = 1;
        @(negedge clk);
        vectors++;
        if (obs !== O_HOLD) begin
            errors++;
            $display("FAIL busy_over_branch: got %b want %b", obs, O_HOLD);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i != 0);
            @(negedge clk);
            vectors++;
            if (obs !== O_HOLD) begin
                errors++;
                $display("FAIL mem_wait_hold[%0d]: got %b want %b", i, obs, O_HOLD);
            end
            next_cycle();
        end
        mem_busy = 0; ex_branch_taken = 0;
        ex_mem_read = 1; ex_rt = 5'd4; id_rs = 5'd4;
        @(negedge clk);
        vectors++;
        if (obs !== O_DEF) begin
            errors++;
            $display("FAIL mem_wait_release: got %b want %b", obs, O_DEF);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if (stall_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_count: got %0d want 3", stall_count);
        end
`endif
        next_cycle();
        @(negedge clk);
        vectors++;
        if (obs !== O_STALL) begin
            errors++;
            $display("FAIL mem_wait_back_to_run: got %b want %b", obs, O_STALL);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== O_HOLD) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: got %b want %b", i, obs, O_HOLD);
            end
            next_cycle();
        end
        // Back in RUN with memory still busy: new hold, error now visible.
        @(negedge clk);
        vectors++;
        if (obs !== (O_HOLD | 7'b1)) begin
            errors++;
            $display("FAIL timeout_err_set: got %b want %b", obs, O_HOLD | 7'b1);
        end
        next_cycle();
        mem_busy = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== (O_DEF | 7'b1)) begin
                errors++;
                $display("FAIL timeout_err_sticky[%0d]: got %b want %b", i, obs, O_DEF | 7'b1);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_busy = 1;
        next_cycle();
        next_cycle();
        rst = 1;
        @(negedge clk);
        vectors++;
        if (obs !== O_RST) begin
            errors++;
            $display("FAIL reset_mid_wait: got %b want %b", obs, O_RST);
        end
        next_cycle();
        rst = 0; mem_busy = 0;
        ex_mem_read = 1; ex_rt = 5'd6; id_rs = 5'd6;
        @(negedge clk);
        vectors++;
        if (obs !== O_STALL) begin
            errors++;
            $display("FAIL after_reset_run: got %b want %b", obs, O_STALL);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if ({stall_count, flush_count} !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_counters: got %0d/%0d want 0/0", stall_count, flush_count);
        end
`endif
        next_cycle();
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 99) == 0);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) != 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 7);
            mem_busy = (burst != 0);
            if (burst != 0) burst--;
            model_eval();
            @(negedge clk);
            vectors++;
            if (obs !== m_exp) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", cyc, obs, m_exp);
            end
`ifdef HAZARD_STATS_EN
            vectors++;
            if (!rst && (stall_count !== 16'(m_stalls) || flush_count !== 16'(m_flushes))) begin
                errors++;
                $display("FAIL random_counts[%0d]: got %0d/%0d want %0d/%0d", cyc,
                         stall_count, flush_count, m_stalls, m_flushes);
            end
`endif
            @(posedge clk);
            model_step();
            #1;
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        quiet_inputs();
        #1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
